neuron_accum_ctrl: RTL and testbench



---
 rtl/neuron_pkg.sv | 23 ++
 rtl/neuron_accum_fsm.sv | 104 ++++++++++
 rtl/neuron_accum_ctrl.sv | 105 ++++++++++
 tb/tb_neuron_accum_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types for the neuron accumulation path: the 1/6/12 float format
// carried from the multiplier and the accumulator controller state encoding.
package neuron_pkg;

  localparam int SIGN_W  = 1;
  localparam int EXP_W   = 6;
  localparam int MANT_W  = 12;
  localparam int FLOAT_W = SIGN_W + EXP_W + MANT_W;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W-1:0] mantissa;
  } float_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IN  = 2'd1,
    ADD_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/neuron_accum_fsm.sv
// Sequencing for the accumulator: term count, adder latency timer and state.
// Emits one-cycle datapath strobes; the datapath registers live in the parent.
module neuron_accum_fsm
  import neuron_pkg::*;
#(
  parameter int ADDER_LAT = 1,
  parameter int CNT_W     = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [CNT_W-1:0] NumTerms,
  input  logic             InValid,
  output logic             InReady,
  output logic             Busy,
  output logic             SumValid,
  output logic             startAcc,
  output logic             clearAcc,
  output logic             loadFirst,
  output logic             issueAdd,
  output logic             capture,
  output logic [1:0]       DbgState
);

  localparam int TMR_W = $clog2(ADDER_LAT + 1);
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(ADDER_LAT);

  state_t           state;
  logic [CNT_W-1:0] numLatched;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic [TMR_W-1:0] timer;
  logic             accept;

  // Handshake: a term transfers on a rising edge where InValid and InReady are
  // both high; InReady is a pure decode of WAIT_IN and never depends on InValid.
  assign InReady   = (state == WAIT_IN);
  assign accept    = InValid && InReady;
  assign countNext = count + CNT_W'(1);
  assign startAcc  = (state == IDLE) && Start && (NumTerms != '0);
  assign clearAcc  = (state == IDLE) && Start && (NumTerms == '0);
  assign loadFirst = accept && (count == '0);
  assign issueAdd  = accept && (count != '0);
  assign capture   = (state == ADD_WAIT) && (timer == TMR_W'(1));
  assign DbgState  = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      numLatched <= '0;
      count      <= '0;
      timer      <= '0;
      Busy       <= 1'b0;
      SumValid   <= 1'b0;
    end else begin
      SumValid <= 1'b0;
      case (state)
        IDLE: begin
          if (startAcc) begin
            numLatched <= NumTerms;
            count      <= '0;
            Busy       <= 1'b1;
            state      <= WAIT_IN;
          end else if (clearAcc) begin
            Busy     <= 1'b1;
            SumValid <= 1'b1;
            state    <= DONE;
          end
        end
        WAIT_IN: begin
          // The first term seeds the accumulator without an adder pass.
          if (loadFirst) begin
            count <= CNT_W'(1);
            if (numLatched == CNT_W'(1)) begin
              SumValid <= 1'b1;
              state    <= DONE;
            end
          end else if (issueAdd) begin
            timer <= TMR_INIT;
            state <= ADD_WAIT;
          end
        end
        ADD_WAIT: begin
          timer <= timer - TMR_W'(1);
          if (capture) begin
            count <= countNext;
            if (countNext == numLatched) begin
              SumValid <= 1'b1;
              state    <= DONE;
            end else begin
              state <= WAIT_IN;
            end
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/neuron_accum_ctrl.sv
// Neuron accumulator: feeds product terms through an externally shared adder,
// holding operands stable across the adder latency, and reports the final sum.
module neuron_accum_ctrl
  import neuron_pkg::*;
#(
  parameter int ADDER_LAT = 1,
  parameter int CNT_W     = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [CNT_W-1:0]  NumTerms,
  input  logic              InValid,
  output logic              InReady,
  input  logic              InSign,
  input  logic [EXP_W-1:0]  InExponent,
  input  logic [MANT_W-1:0] InMantissa,
  output logic              AddSignA,
  output logic [EXP_W-1:0]  AddExponentA,
  output logic [MANT_W-1:0] AddMantissaA,
  output logic              AddSignB,
  output logic [EXP_W-1:0]  AddExponentB,
  output logic [MANT_W-1:0] AddMantissaB,
  input  logic              AddSignOut,
  input  logic [EXP_W-1:0]  AddExponentOut,
  input  logic [MANT_W-1:0] AddMantissaOut,
  input  logic              AddCout,
  output logic              Busy,
  output logic              SumValid,
  output logic              SumSign,
  output logic [EXP_W-1:0]  SumExponent,
  output logic [MANT_W-1:0] SumMantissa,
  output logic              Overflow,
  output logic [1:0]        DbgState
);

  float_t acc;
  float_t opA;
  float_t opB;
  float_t term;
  float_t addResult;
  logic   ovf;
  logic   startAcc;
  logic   clearAcc;
  logic   loadFirst;
  logic   issueAdd;
  logic   capture;

  assign term      = {InSign, InExponent, InMantissa};
  assign addResult = {AddSignOut, AddExponentOut, AddMantissaOut};

  neuron_accum_fsm #(
    .ADDER_LAT (ADDER_LAT),
    .CNT_W     (CNT_W)
  ) uFsm (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .NumTerms  (NumTerms),
    .InValid   (InValid),
    .InReady   (InReady),
    .Busy      (Busy),
    .SumValid  (SumValid),
    .startAcc  (startAcc),
    .clearAcc  (clearAcc),
    .loadFirst (loadFirst),
    .issueAdd  (issueAdd),
    .capture   (capture),
    .DbgState  (DbgState)
  );

  // Operand registers change only on issue so the adder sees stable inputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc <= '0;
      opA <= '0;
      opB <= '0;
      ovf <= 1'b0;
    end else begin
      if (clearAcc) acc <= '0;
      if (startAcc) ovf <= 1'b0;
      if (loadFirst) acc <= term;
      if (issueAdd) begin
        opA <= acc;
        opB <= term;
      end
      if (capture) begin
        acc <= addResult;
        ovf <= ovf | AddCout;
      end
    end
  end

  assign AddSignA     = opA.sign;
  assign AddExponentA = opA.exponent;
  assign AddMantissaA = opA.mantissa;
  assign AddSignB     = opB.sign;
  assign AddExponentB = opB.exponent;
  assign AddMantissaB = opB.mantissa;
  assign SumSign      = acc.sign;
  assign SumExponent  = acc.exponent;
  assign SumMantissa  = acc.mantissa;
  assign Overflow     = ovf;

endmodule

// File: tb/tb_neuron_accum_ctrl.sv
// Bench for neuron_accum_ctrl: a combinational adder stub with a forceable
// carry, a term-level reference fold, and a scoreboard of expected sums.
module tb_neuron_accum_ctrl;
  import neuron_pkg::*;

  localparam int ADDER_LAT = 2;
  localparam int CNT_W     = 8;
  localparam int W         = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_terms = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sign = 1'b0;
  logic [5:0]       in_exp = '0;
  logic [11:0]      in_mant = '0;
  logic             a_sign, b_sign;
  logic [5:0]       a_exp, b_exp;
  logic [11:0]      a_mant, b_mant;
  logic             add_sign_out, add_cout;
  logic [5:0]       add_exp_out;
  logic [11:0]      add_mant_out;
  logic             force_cout = 1'b0;
  logic             busy, sum_valid, sum_sign, overflow;
  logic [5:0]       sum_exp;
  logic [11:0]      sum_mant;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [18:0]   terms[256];

  always #5 clk = ~clk;

  neuron_accum_ctrl #(.ADDER_LAT(ADDER_LAT), .CNT_W(CNT_W)) dut (
    .Clock(clk), .Reset(rst), .Start(start), .NumTerms(num_terms),
    .InValid(in_valid), .InReady(in_ready),
    .InSign(in_sign), .InExponent(in_exp), .InMantissa(in_mant),
    .AddSignA(a_sign), .AddExponentA(a_exp), .AddMantissaA(a_mant),
    .AddSignB(b_sign), .AddExponentB(b_exp), .AddMantissaB(b_mant),
    .AddSignOut(add_sign_out), .AddExponentOut(add_exp_out),
    .AddMantissaOut(add_mant_out), .AddCout(add_cout),
    .Busy(busy), .SumValid(sum_valid),
    .SumSign(sum_sign), .SumExponent(sum_exp), .SumMantissa(sum_mant),
    .Overflow(overflow), .DbgState(dbg_state)
  );

  // Toy adder: xor signs, larger exponent, mantissa sum with carry-out.
  function automatic logic [W-1:0] adder_model(input logic [18:0] a, input logic [18:0] b,
                                               input logic frc);
    logic [12:0] msum;
    logic [5:0]  e;
    msum = {1'b0, a[11:0]} + {1'b0, b[11:0]};
    e = (a[17:12] > b[17:12]) ? a[17:12] : b[17:12];
    return {msum[12] | frc, a[18] ^ b[18], e, msum[11:0]};
  endfunction

  assign {add_cout, add_sign_out, add_exp_out, add_mant_out} =
    adder_model({a_sign, a_exp, a_mant}, {b_sign, b_exp, b_mant}, force_cout);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_terms(input int n, input int mant_max);
    for (int i = 0; i < n; i++)
      terms[i] = {1'(($urandom_range(1, 0))), 6'($urandom_range(63, 0)),
                  12'($urandom_range(mant_max, 0))};
  endtask

  task automatic run_acc(input int n, input int stall_lo, input int stall_hi,
                         input bit pulse_start, input int force_idx);
    int          idx, c, stall_left, total_stall, exp_cyc;
    bit          any_ready, ops_live, got;
    logic [18:0] model_acc, exp_a, exp_b, t;
    logic        model_ovf;
    logic [W-1:0] r, exp_sum;
    idx = 0; total_stall = 0; any_ready = 0; ops_live = 0; got = 0;
    model_acc = '0; model_ovf = 1'b0; exp_a = '0; exp_b = '0; exp_sum = '0;
    stall_left = $urandom_range(stall_hi, stall_lo);
    if (n == 0) exp_q.push_back('0);
    @(negedge clk);
    start = 1'b1;
    num_terms = n[CNT_W-1:0];
    @(posedge clk);
    for (c = 1; c <= 4000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        check_eq("busy_after_start", busy, 1);
        if (n != 0) check_eq("overflow_cleared", overflow, 0);
      end
      if (ops_live) begin
        check_eq("operand_a", {a_sign, a_exp, a_mant}, exp_a);
        check_eq("operand_b", {b_sign, b_exp, b_mant}, exp_b);
      end
      if (sum_valid) begin
        got = 1;
        break;
      end
      if (pulse_start && c == 3) begin
        start = 1'b1;
        num_terms = CNT_W'($urandom_range(255, 1));
      end
      if (in_ready) begin
        any_ready = 1;
        if (stall_left > 0) begin
          in_valid = 1'b0;
          stall_left--;
          total_stall++;
        end else begin
          t = (idx < n) ? terms[idx] : 19'($urandom);
          in_valid = 1'b1;
          {in_sign, in_exp, in_mant} = t;
          if (idx == 0) begin
            model_acc = t;
          end else begin
            exp_a = model_acc;
            exp_b = t;
            force_cout = (idx == force_idx);
            r = adder_model(model_acc, t, idx == force_idx);
            model_ovf = model_ovf | r[19];
            model_acc = r[18:0];
            ops_live = 1;
          end
          idx++;
          if (idx == n) exp_q.push_back({model_ovf, model_acc});
          stall_left = $urandom_range(stall_hi, stall_lo);
        end
      end else begin
        in_valid = 1'($urandom_range(1, 0));
        {in_sign, in_exp, in_mant} = 19'($urandom);
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    check_eq("sum_valid_seen", got, 1);
    if (got) begin
      exp_cyc = (n == 0) ? 1 : 2 + (n - 1) * (ADDER_LAT + 1) + total_stall;
      check_eq("done_cycle", c, exp_cyc);
      check_eq("terms_accepted", idx, n);
      check_eq("in_ready_seen", any_ready, (n != 0));
      check_eq("scoreboard_entry", exp_q.size(), 1);
      if (exp_q.size() > 0) exp_sum = exp_q.pop_front();
      check_eq("sum", {sum_sign, sum_exp, sum_mant}, exp_sum[18:0]);
      if (n != 0) check_eq("overflow", overflow, exp_sum[19]);
      @(negedge clk);
      check_eq("sum_valid_pulse", sum_valid, 0);
      check_eq("busy_after_done", busy, 0);
      check_eq("sum_held", {sum_sign, sum_exp, sum_mant}, exp_sum[18:0]);
    end else begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    exp_q.delete();
    force_cout = 1'b0;
  endtask

  initial begin
    int  acc_cnt;
    bit  seen_wait;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_sum_valid", sum_valid, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_sum", {sum_sign, sum_exp, sum_mant}, 0);
    check_eq("rst_state", dbg_state, 0);

    terms[0] = {1'b0, 6'd7, 12'h03F};
    run_acc(1, 0, 0, 0, -1);
    check_eq("single_no_issue_a", {a_sign, a_exp, a_mant}, 0);
    check_eq("single_no_issue_b", {b_sign, b_exp, b_mant}, 0);
    check_eq("single_sum", {sum_sign, sum_exp, sum_mant}, {1'b0, 6'd7, 12'h03F});

    terms[0] = {1'b0, 6'd7, 12'h03F};
    terms[1] = {1'b0, 6'd7, 12'h1DC};
    run_acc(2, 0, 0, 0, -1);
    check_eq("pair_mant_a", a_mant, 12'h03F);
    check_eq("pair_mant_b", b_mant, 12'h1DC);
    check_eq("pair_sum", {sum_sign, sum_exp, sum_mant}, {1'b0, 6'd7, 12'h21B});

    run_acc(0, 0, 0, 0, -1);

    fill_terms(4, 4095);
    run_acc(4, 3, 3, 1, -1);

    terms[0] = {1'b0, 6'd3, 12'h010};
    terms[1] = {1'b0, 6'd4, 12'h020};
    terms[2] = {1'b0, 6'd5, 12'h030};
    run_acc(3, 0, 0, 0, 1);
    check_eq("forced_overflow", overflow, 1);
    fill_terms(2, 255);
    run_acc(2, 0, 0, 0, -1);

    repeat (25) begin
      int n;
      n = $urandom_range(8, 0);
      fill_terms(n, 4095);
      run_acc(n, 0, 2, 1'($urandom_range(1, 0)), int'($urandom_range(8, 0)) - 1);
    end

    fill_terms(255, 4095);
    run_acc(255, 0, 0, 0, -1);

    @(negedge clk);
    start = 1'b1;
    num_terms = 8'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    {in_sign, in_exp, in_mant} = 19'h00123;
    acc_cnt = 0;
    seen_wait = 0;
    for (int c = 0; c < 40; c++) begin
      if (in_ready) acc_cnt++;
      else if (acc_cnt >= 2) begin
        seen_wait = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("reached_add_wait", seen_wait, 1);
    check_eq("state_add_wait", dbg_state, 2);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_state", dbg_state, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    check_eq("midrst_sum_valid", sum_valid, 0);
    check_eq("midrst_overflow", overflow, 0);
    check_eq("midrst_sum", {sum_sign, sum_exp, sum_mant}, 0);
    check_eq("midrst_op_a", {a_sign, a_exp, a_mant}, 0);
    check_eq("midrst_op_b", {b_sign, b_exp, b_mant}, 0);
    @(negedge clk);
    check_eq("midrst_stays_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
